// File: rtl/invtlb_ctrl_pkg.sv
// Shared constants and types for the INVTLB sweep sequencer.
//   INVTLB_TLBNUM      : default number of TLB entries
//   INVTLB_OP_*        : INVTLB op encodings 0..6
//   PS_4K / PS_4M      : page-size codes understood by the VA compare
//   inv_state_e        : sequencer states
//   tlb_entry_t        : one TLB entry as carried on the read/write ports
package invtlb_ctrl_pkg;

    localparam int unsigned INVTLB_TLBNUM = 16;

    localparam logic [4:0] INVTLB_OP_ALL0          = 5'd0;
    localparam logic [4:0] INVTLB_OP_ALL1          = 5'd1;
    localparam logic [4:0] INVTLB_OP_GTRUE         = 5'd2;
    localparam logic [4:0] INVTLB_OP_GFALSE        = 5'd3;
    localparam logic [4:0] INVTLB_OP_GFALSE_ASID   = 5'd4;
    localparam logic [4:0] INVTLB_OP_GFALSE_ASIDVA = 5'd5;
    localparam logic [4:0] INVTLB_OP_GASID_VA      = 5'd6;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } inv_state_e;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

endpackage

// File: rtl/invtlb_ctrl_match.sv
// Combinational INVTLB entry match; reusable for TLBSRCH-style checks.
//   i_op              : INVTLB op code
//   i_asid / i_vppn   : requested ASID and VPPN (va[31:13])
//   i_e, i_g          : entry valid and global bits
//   i_e_asid/vppn/ps  : entry ASID, VPPN and page size
//   o_hit_c           : entry is valid and selected by the op
module invtlb_match
    import invtlb_ctrl_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [9:0]  i_asid,
    input  logic [18:0] i_vppn,
    input  logic        i_e,
    input  logic        i_g,
    input  logic [9:0]  i_e_asid,
    input  logic [18:0] i_e_vppn,
    input  logic [5:0]  i_e_ps,
    output logic        o_hit_c
);

    logic w_asid_eq;
    logic w_va_eq;
    logic w_sel;

    // VA compare granularity follows the entry's page size; unknown sizes never match.
    always_comb begin
        w_asid_eq = (i_asid == i_e_asid);
        w_va_eq   = 1'b0;
        if (i_e_ps == PS_4K) begin
            w_va_eq = (i_vppn == i_e_vppn);
        end else if (i_e_ps == PS_4M) begin
            w_va_eq = (i_vppn[18:9] == i_e_vppn[18:9]);
        end
    end

    // Op-dependent selection; reserved ops select nothing.
    always_comb begin
        w_sel = 1'b0;
        case (i_op)
            INVTLB_OP_ALL0,
            INVTLB_OP_ALL1:          w_sel = 1'b1;
            INVTLB_OP_GTRUE:         w_sel = i_g;
            INVTLB_OP_GFALSE:        w_sel = ~i_g;
            INVTLB_OP_GFALSE_ASID:   w_sel = ~i_g & w_asid_eq;
            INVTLB_OP_GFALSE_ASIDVA: w_sel = ~i_g & w_asid_eq & w_va_eq;
            INVTLB_OP_GASID_VA:      w_sel = (i_g | w_asid_eq) & w_va_eq;
            default:                 w_sel = 1'b0;
        endcase
    end

    assign o_hit_c = i_e & w_sel;

endmodule

// File: rtl/invtlb_ctrl.sv
// INVTLB sequencer: sweeps every TLB entry through the shared read/write
// ports, one per cycle, clearing E on entries selected by the op.
//   clk, resetn          : clock, synchronous active-low reset
//   inv_req/op/asid/va   : committing INVTLB from WB (held until inv_done)
//   inv_busy             : sweep owns the TLB ports
//   inv_done             : one-cycle completion pulse
//   inv_count            : entries cleared by the last completed op
//   tlb_r_index, tlb_r_* : read port (data is combinational on the index)
//   tlb_we, tlb_w_*      : write port; data is the read entry with E = 0
module invtlb_ctrl
    import invtlb_ctrl_pkg::*;
#(
    parameter int unsigned TLBNUM = INVTLB_TLBNUM,
    parameter int unsigned IDXW   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inv_req,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [31:0]     inv_va,
    output logic            inv_busy,
    output logic            inv_done,
    output logic [4:0]      inv_count,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic            tlb_r_e,
    input  logic [18:0]     tlb_r_vppn,
    input  logic [5:0]      tlb_r_ps,
    input  logic [9:0]      tlb_r_asid,
    input  logic            tlb_r_g,
    input  logic [19:0]     tlb_r_ppn0,
    input  logic [1:0]      tlb_r_plv0,
    input  logic [1:0]      tlb_r_mat0,
    input  logic            tlb_r_d0,
    input  logic            tlb_r_v0,
    input  logic [19:0]     tlb_r_ppn1,
    input  logic [1:0]      tlb_r_plv1,
    input  logic [1:0]      tlb_r_mat1,
    input  logic            tlb_r_d1,
    input  logic            tlb_r_v1,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            tlb_w_e,
    output logic [18:0]     tlb_w_vppn,
    output logic [5:0]      tlb_w_ps,
    output logic [9:0]      tlb_w_asid,
    output logic            tlb_w_g,
    output logic [19:0]     tlb_w_ppn0,
    output logic [1:0]      tlb_w_plv0,
    output logic [1:0]      tlb_w_mat0,
    output logic            tlb_w_d0,
    output logic            tlb_w_v0,
    output logic [19:0]     tlb_w_ppn1,
    output logic [1:0]      tlb_w_plv1,
    output logic [1:0]      tlb_w_mat1,
    output logic            tlb_w_d1,
    output logic            tlb_w_v1
);

    localparam int unsigned CNTW = 5;

    inv_state_e      r_state;
    inv_state_e      w_state_nxt;
    logic [4:0]      r_op;
    logic [9:0]      r_asid;
    logic [18:0]     r_vppn;
    logic [IDXW:0]   r_idx;
    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] r_inv_count;

    logic            w_sweep;
    logic            w_hit;
    logic            w_we;
    logic            w_accept;
    logic            w_fin;
    logic [IDXW:0]   w_idx_nxt;
    logic [CNTW-1:0] w_count_nxt;
    tlb_entry_t      w_rd_entry;
    tlb_entry_t      w_wr_entry;
    logic            w_unused_va;

    // Page offset bits of the VA operand play no part in any compare.
    assign w_unused_va = ^inv_va[12:0];

    assign w_sweep   = (r_state == ST_SWEEP);
    assign w_idx_nxt = r_idx + (IDXW+1)'(1);

    invtlb_match u_match (
        .i_op     (r_op),
        .i_asid   (r_asid),
        .i_vppn   (r_vppn),
        .i_e      (tlb_r_e),
        .i_g      (tlb_r_g),
        .i_e_asid (tlb_r_asid),
        .i_e_vppn (tlb_r_vppn),
        .i_e_ps   (tlb_r_ps),
        .o_hit_c  (w_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_accept    = 1'b0;
        w_fin       = 1'b0;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (inv_req) begin
                    w_accept = 1'b1;
                    // Reserved ops are trapped in ID; finish with nothing cleared.
                    if (inv_op > INVTLB_OP_GASID_VA) begin
                        w_state_nxt = ST_DONE;
                        w_fin       = 1'b1;
                        w_count_nxt = '0;
                    end else begin
                        w_state_nxt = ST_SWEEP;
                    end
                end
            end
            ST_SWEEP: begin
                w_we        = w_hit;
                w_count_nxt = r_count + CNTW'(w_hit);
                // Extra index bit makes the terminal compare unambiguous.
                if (w_idx_nxt == (IDXW+1)'(TLBNUM)) begin
                    w_state_nxt = ST_DONE;
                    w_fin       = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch, sweep index and hit counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op        <= '0;
            r_asid      <= '0;
            r_vppn      <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_inv_count <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= inv_op;
                r_asid  <= inv_asid;
                r_vppn  <= inv_va[31:13];
                r_idx   <= '0;
                r_count <= '0;
            end else if (w_sweep) begin
                r_idx   <= w_idx_nxt;
                r_count <= w_count_nxt;
            end
            if (w_fin) begin
                r_inv_count <= w_count_nxt;
            end
        end
    end

    // Write data is the entry just read with E cleared; idle ports read as zero.
    always_comb begin
        w_rd_entry      = '0;
        w_rd_entry.e    = tlb_r_e;
        w_rd_entry.vppn = tlb_r_vppn;
        w_rd_entry.ps   = tlb_r_ps;
        w_rd_entry.asid = tlb_r_asid;
        w_rd_entry.g    = tlb_r_g;
        w_rd_entry.ppn0 = tlb_r_ppn0;
        w_rd_entry.plv0 = tlb_r_plv0;
        w_rd_entry.mat0 = tlb_r_mat0;
        w_rd_entry.d0   = tlb_r_d0;
        w_rd_entry.v0   = tlb_r_v0;
        w_rd_entry.ppn1 = tlb_r_ppn1;
        w_rd_entry.plv1 = tlb_r_plv1;
        w_rd_entry.mat1 = tlb_r_mat1;
        w_rd_entry.d1   = tlb_r_d1;
        w_rd_entry.v1   = tlb_r_v1;
        w_wr_entry      = '0;
        if (w_sweep) begin
            w_wr_entry   = w_rd_entry;
            w_wr_entry.e = 1'b0;
        end
    end

    assign inv_busy    = (r_state != ST_IDLE);
    assign inv_done    = (r_state == ST_DONE);
    assign inv_count   = r_inv_count;

    assign tlb_r_index = w_sweep ? r_idx[IDXW-1:0] : '0;
    assign tlb_w_index = tlb_r_index;
    // Reset takes effect on the write strobe in the same cycle it is asserted.
    assign tlb_we      = w_we & resetn;

    assign tlb_w_e     = w_wr_entry.e;
    assign tlb_w_vppn  = w_wr_entry.vppn;
    assign tlb_w_ps    = w_wr_entry.ps;
    assign tlb_w_asid  = w_wr_entry.asid;
    assign tlb_w_g     = w_wr_entry.g;
    assign tlb_w_ppn0  = w_wr_entry.ppn0;
    assign tlb_w_plv0  = w_wr_entry.plv0;
    assign tlb_w_mat0  = w_wr_entry.mat0;
    assign tlb_w_d0    = w_wr_entry.d0;
    assign tlb_w_v0    = w_wr_entry.v0;
    assign tlb_w_ppn1  = w_wr_entry.ppn1;
    assign tlb_w_plv1  = w_wr_entry.plv1;
    assign tlb_w_mat1  = w_wr_entry.mat1;
    assign tlb_w_d1    = w_wr_entry.d1;
    assign tlb_w_v1    = w_wr_entry.v1;

endmodule

// File: tb/tb_invtlb_ctrl.sv
// Directed bench for invtlb_ctrl with a TLB memory model and a scoreboard of
// expected write indices and completion counts.
module tb_invtlb_ctrl;
    import invtlb_ctrl_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inv_req;
    logic [4:0]    inv_op;
    logic [9:0]    inv_asid;
    logic [31:0]   inv_va;
    logic          inv_busy, inv_done;
    logic [4:0]    inv_count;
    logic [IW-1:0] tlb_r_index, tlb_w_index;
    logic          tlb_we, tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
    logic [18:0]   tlb_w_vppn;
    logic [5:0]    tlb_w_ps;
    logic [9:0]    tlb_w_asid;
    logic [19:0]   tlb_w_ppn0, tlb_w_ppn1;
    logic [1:0]    tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;

    tlb_entry_t mem [N];
    tlb_entry_t img [N];
    tlb_entry_t rd, wr, mon_exp;
    logic       load_en;
    int unsigned q_wr[$];
    int unsigned q_cnt[$];
    int unsigned mon_ei;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rd = mem[tlb_r_index];
    assign wr = '{e: tlb_w_e, vppn: tlb_w_vppn, ps: tlb_w_ps, asid: tlb_w_asid, g: tlb_w_g,
                  ppn0: tlb_w_ppn0, plv0: tlb_w_plv0, mat0: tlb_w_mat0, d0: tlb_w_d0, v0: tlb_w_v0,
                  ppn1: tlb_w_ppn1, plv1: tlb_w_plv1, mat1: tlb_w_mat1, d1: tlb_w_d1, v1: tlb_w_v1};

    invtlb_ctrl #(.TLBNUM(N), .IDXW(IW)) dut (
        .clk(clk), .resetn(resetn),
        .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .inv_busy(inv_busy), .inv_done(inv_done), .inv_count(inv_count),
        .tlb_r_index(tlb_r_index),
        .tlb_r_e(rd.e), .tlb_r_vppn(rd.vppn), .tlb_r_ps(rd.ps), .tlb_r_asid(rd.asid), .tlb_r_g(rd.g),
        .tlb_r_ppn0(rd.ppn0), .tlb_r_plv0(rd.plv0), .tlb_r_mat0(rd.mat0), .tlb_r_d0(rd.d0), .tlb_r_v0(rd.v0),
        .tlb_r_ppn1(rd.ppn1), .tlb_r_plv1(rd.plv1), .tlb_r_mat1(rd.mat1), .tlb_r_d1(rd.d1), .tlb_r_v1(rd.v1),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
        .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
        .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
        .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
        .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1)
    );

    // TLB storage: bulk preload or a single write from the DUT.
    always @(posedge clk) begin
        if (load_en) mem <= img;
        else if (tlb_we) mem[tlb_w_index] <= wr;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected selection, written directly from the op table.
    function automatic bit exp_hit(input tlb_entry_t t, input logic [4:0] op,
                                   input logic [9:0] as, input logic [18:0] vp);
        bit va_ok, as_ok;
        as_ok = (t.asid == as);
        if (t.ps == 6'd12)      va_ok = (t.vppn == vp);
        else if (t.ps == 6'd21) va_ok = (t.vppn[18:9] == vp[18:9]);
        else                    va_ok = 1'b0;
        if (!t.e) return 1'b0;
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return t.g;
            5'd3:       return !t.g;
            5'd4:       return !t.g && as_ok;
            5'd5:       return !t.g && as_ok && va_ok;
            5'd6:       return (t.g || as_ok) && va_ok;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] evec();
        logic [15:0] v;
        for (int i = 0; i < N; i++) v[i] = mem[i].e;
        return v;
    endfunction

    task automatic base_img();
        for (int i = 0; i < N; i++) begin
            img[i].e    = 1'b1;
            img[i].vppn = 19'(32'h100 + i * 32'h1111);
            img[i].ps   = 6'd12;
            img[i].asid = 10'(i + 1);
            img[i].g    = 1'b0;
            img[i].ppn0 = 20'(32'h8000 + i * 7);
            img[i].plv0 = 2'(i);
            img[i].mat0 = 2'(i + 1);
            img[i].d0   = i[0];
            img[i].v0   = 1'b1;
            img[i].ppn1 = 20'(32'h9000 + i * 13);
            img[i].plv1 = 2'(i + 2);
            img[i].mat1 = 2'(i + 3);
            img[i].d1   = ~i[0];
            img[i].v1   = i[1];
        end
    endtask

    task automatic load();
        @(negedge clk); load_en = 1'b1;
        @(negedge clk); load_en = 1'b0;
    endtask

    // Issue one INVTLB from an IDLE negedge and follow it to completion.
    task automatic run_op(input logic [4:0] op, input logic [9:0] as, input logic [31:0] va,
                          input int lat, input string tag);
        int n;
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (exp_hit(mem[i], op, as, va[31:13])) begin
                q_wr.push_back(i);
                cnt++;
            end
        end
        q_cnt.push_back(cnt);
        inv_req = 1'b1; inv_op = op; inv_asid = as; inv_va = va;
        @(posedge clk); @(negedge clk);
        chk({tag, "_busy"}, 96'(inv_busy), 96'(1));
        n = 0;
        while (!inv_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 96'(n), 96'(lat));
        // req is still high across the DONE edge and must not restart a sweep.
        @(posedge clk); @(negedge clk);
        chk({tag, "_noreacc"}, 96'(inv_busy), 96'(0));
        chk({tag, "_nodup"}, 96'(inv_done), 96'(0));
        chk({tag, "_wrq"}, 96'(q_wr.size()), 96'(0));
        chk({tag, "_cntq"}, 96'(q_cnt.size()), 96'(0));
        inv_req = 1'b0;
    endtask

    // Scoreboard: every write and every completion is matched against the queues.
    always @(negedge clk) begin
        if (tlb_we) begin
            chk("we_in_sweep", 96'(inv_busy), 96'(1));
            if (q_wr.size() == 0) begin
                chk("spurious_we", 96'(tlb_we), 96'(0));
            end else begin
                mon_ei = q_wr.pop_front();
                chk("wr_idx", 96'(tlb_w_index), 96'(mon_ei));
                mon_exp   = mem[mon_ei];
                mon_exp.e = 1'b0;
                chk("wr_data", 96'(wr), 96'(mon_exp));
            end
        end
        if (inv_done) begin
            if (q_cnt.size() == 0) chk("spurious_done", 96'(inv_done), 96'(0));
            else chk("inv_count", 96'(inv_count), 96'(q_cnt.pop_front()));
        end
    end

    initial begin
        int n;
        resetn = 1'b0; inv_req = 1'b0; inv_op = '0; inv_asid = '0; inv_va = '0; load_en = 1'b0;
        base_img();
        load();
        @(negedge clk);
        chk("rst_busy",  96'(inv_busy), 96'(0));
        chk("rst_done",  96'(inv_done), 96'(0));
        chk("rst_we",    96'(tlb_we), 96'(0));
        chk("rst_ridx",  96'(tlb_r_index), 96'(0));
        chk("rst_widx",  96'(tlb_w_index), 96'(0));
        chk("rst_count", 96'(inv_count), 96'(0));
        chk("rst_wdata", 96'(wr), 96'(0));
        resetn = 1'b1;
        @(negedge clk);

        // op 0 clears everything in 16 consecutive cycles.
        run_op(5'd0, 10'h0, 32'h0, 16, "op0");
        chk("op0_cnt", 96'(inv_count), 96'(16));
        chk("op0_e", 96'(evec()), 96'(16'h0000));

        // op 2: only the valid global entry 3 is cleared.
        base_img(); img[3].g = 1'b1; img[7].g = 1'b1; img[7].e = 1'b0;
        load();
        run_op(5'd2, 10'h0, 32'h0, 16, "op2");
        chk("op2_cnt", 96'(inv_count), 96'(1));
        chk("op2_e", 96'(evec()), 96'(16'hFF77));

        // op 5: 4K and 4M entries with matching VA, plus near misses.
        base_img();
        img[4].vppn = 19'h091A3; img[4].asid = 10'h005; img[4].ps = 6'd12; img[4].g = 1'b0;
        img[9].vppn = 19'h09000; img[9].asid = 10'h005; img[9].ps = 6'd21; img[9].g = 1'b0;
        img[5].vppn = 19'h091A2; img[5].asid = 10'h005;
        img[6].vppn = 19'h091A3; img[6].asid = 10'h006;
        img[8].vppn = 19'h091A3; img[8].asid = 10'h005; img[8].g = 1'b1;
        load();
        run_op(5'd5, 10'h005, 32'h1234_6000, 16, "op5");
        chk("op5_cnt", 96'(inv_count), 96'(2));
        chk("op5_e", 96'(evec()), 96'(16'hFDEF));

        // Reserved op: done right after acceptance, nothing written.
        run_op(5'd7, 10'h005, 32'h1234_6000, 0, "op7");
        chk("op7_cnt", 96'(inv_count), 96'(0));
        chk("op7_e", 96'(evec()), 96'(16'hFDEF));

        // Back-to-back: op 4 then op 6 with the second raised right after DONE.
        base_img();
        img[12].g = 1'b1; img[12].ps = 6'd21; img[12].vppn = 19'h09A00;
        load();
        run_op(5'd4, 10'h003, 32'h0, 16, "b2b_op4");
        chk("b2b_op4_cnt", 96'(inv_count), 96'(1));
        run_op(5'd6, 10'h00A, {19'h09A99, 13'h0}, 16, "b2b_op6");
        chk("b2b_op6_cnt", 96'(inv_count), 96'(2));
        chk("b2b_e", 96'(evec()), 96'(16'hEDFB));

        // Reset during sweep cycle 5: entries 0-4 cleared, the rest intact.
        base_img();
        load();
        for (int i = 0; i < N; i++) q_wr.push_back(i);
        q_cnt.push_back(16);
        inv_req = 1'b1; inv_op = 5'd0; inv_asid = '0; inv_va = '0;
        @(posedge clk); @(negedge clk);
        n = 0;
        while (tlb_r_index != IW'(4) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach", 96'(tlb_r_index), 96'(4));
        @(posedge clk);
        #1 resetn = 1'b0; inv_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_we_now", 96'(tlb_we), 96'(0));
        @(posedge clk); @(negedge clk);
        chk("rst_mid_busy", 96'(inv_busy), 96'(0));
        chk("rst_mid_we", 96'(tlb_we), 96'(0));
        q_wr.delete();
        q_cnt.delete();
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_idle", 96'(inv_busy), 96'(0));
        chk("rst_mid_e", 96'(evec()), 96'(16'hFFE0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/invtlb_ctrl.md
# invtlb_ctrl

Sequencer that executes INVTLB by sweeping every TLB entry through the shared TLB read and write ports, one entry per cycle. For each entry whose fields satisfy the requested invalidation op, it clears E. It sits beside the write-back stage. WB raises a request when an INVTLB reaches commit and holds the instruction until `inv_done`. While `inv_busy`, this block owns the TLB read index and write port; TLBRD, TLBWR and TLBFILL are muxed out.

## Interface
Parameters:
- `TLBNUM`, 16: number of TLB entries; must be a power of two.
- `IDXW`, 4: index width, equal to log2(TLBNUM).

Ports:
- `clk`  in  1: single clock.
- `resetn`  in  1: reset, synchronous and active-low.
- `inv_req`  in  1: WB has a committing INVTLB; held until `inv_done`.
- `inv_op`  in  5: INVTLB op code.
- `inv_asid`  in  10: ASID operand, from rj[9:0].
- `inv_va`  in  32: VA operand, from rk.
- `inv_busy`  out  1: sweep in progress; WB muxes the TLB ports to this block.
- `inv_done`  out  1: one-cycle completion pulse.
- `inv_count`  out  5: number of entries cleared by the last completed op.
- `tlb_r_index`  out  IDXW: read-port index.
- `tlb_r_e`, `tlb_r_vppn`[18:0], `tlb_r_ps`[5:0], `tlb_r_asid`[9:0], `tlb_r_g`, `tlb_r_ppn0/1`[19:0], `tlb_r_plv0/1`[1:0], `tlb_r_mat0/1`[1:0], `tlb_r_d0/1`, `tlb_r_v0/1`  in: combinational read data for `tlb_r_index`.
- `tlb_we`  out  1: write strobe.
- `tlb_w_index`  out  IDXW: write index.
- `tlb_w_e`  out  1: always 0 when `tlb_we`.
- `tlb_w_*` (vppn, ps, asid, g, ppn0/1, plv0/1, mat0/1, d0/1, v0/1)  out: copied unchanged from the `tlb_r_*` read data.

## Operation
States: IDLE, SWEEP, DONE.

IDLE:
- `inv_req` is accepted only in IDLE.
- On acceptance, latch op, asid and VPPN (va[31:13]); clear idx and the running count; go to SWEEP.
- If the latched op is greater than 6, skip SWEEP and go straight to DONE with count 0. ID raises INE for such ops; this is a defensive path.

SWEEP:
- `tlb_r_index` = idx.
- hit = `tlb_r_e` AND match(op, entry).
- `tlb_we` = hit, `tlb_w_index` = idx, `tlb_w_e` = 0.
- On hit, count is incremented.
- idx is incremented; after idx == TLBNUM-1, go to DONE.

Match rules by op:
- op 0 and op 1: all entries.
- op 2: G = 1.
- op 3: G = 0.
- op 4: G = 0 and ASID equal.
- op 5: G = 0, ASID equal, and VA match.
- op 6: (G = 1 or ASID equal) and VA match.

VA match depends on the entry's page size:
- ps = 12: compare vppn[18:0].
- ps = 21: compare vppn[18:9].

Entries with E = 0 are never written and not counted.

DONE:
- `inv_done` = 1 and `inv_count` takes the final count.
- Unconditionally return to IDLE. `inv_req` seen while in DONE belongs to the finishing instruction and is not accepted.

## Timing
- Reset values: state IDLE; `inv_busy` 0, `inv_done` 0, `tlb_we` 0, `tlb_r_index` 0, `tlb_w_index` 0, `inv_count` 0, and all `tlb_w_*` 0.
- Reset mid-sweep returns to IDLE immediately. No further writes occur, and entries already cleared stay cleared.
- `inv_busy` = (state != IDLE).
- Latency: request accepted at cycle N; entries written in cycles N+1 through N+TLBNUM; `inv_done` in cycle N+TLBNUM+1. That is 18 cycles total for TLBNUM = 16.
- WB handshake: WB uses wb_ready_go = ~`inv_req` | `inv_done`, so WB retires the instruction on the `inv_done` cycle.
- Back-to-back INVTLB: the next request, raised in the cycle after DONE, is accepted from IDLE that cycle.
- `tlb_we` is never asserted outside SWEEP. Exactly one write per cycle at most.
- idx is IDXW+1 bits internally to detect the end of the sweep without wrap ambiguity.
- `inv_count` holds its value until the next DONE.

## Structure
- Constants go in `macros.h`: TLBNUM, the INVTLB op encodings `INVTLB_OP_ALL0` through `INVTLB_OP_GASID_VA` (0–6), and PS_4K = 12, PS_4M = 21.
- One combinational sub-module, `invtlb_match`: inputs op, asid, vppn and the entry fields (e, g, asid, vppn, ps); output hit. It is shared with future TLBSRCH-style checks.
- The state machine, idx, count and write-port drive live in `invtlb_ctrl`.

## Test plan
- TLB preloaded with 16 valid entries; op 0 → `tlb_we` asserted at indices 0–15 in consecutive cycles, `inv_done` at cycle N+17, `inv_count` = 16.
- Entries 3 and 7 have G = 1 and entry 7 has E = 0; op 2 → exactly one write, at index 3, with all other fields unchanged; `inv_count` = 1.
- op 5 with asid = 0x05 and va = 0x1234_6000 against entry 4 (ps 12, vppn 0x091A3, asid 5, G 0) and entry 9 (ps 21, vppn 0x09000, asid 5, G 0) → entry 4 is cleared; entry 9 matches only if va[31:22] equals vppn[18:9], which it does here (0x048 = 0x048), so it is cleared too; `inv_count` = 2.
- op 7 → no `tlb_we` at all; `inv_done` one cycle after acceptance; `inv_count` = 0.
- `resetn` low at sweep cycle 5 → from the next cycle `inv_busy` = 0 and no writes; entries 0–4 are cleared and entries 5–15 are intact.
- Two back-to-back INVTLB requests → the second is accepted the cycle after the first `inv_done`, and there is no duplicate `inv_done`.
